// File: rtl/comp_pkg.sv
// comp_pkg: FSM states, vector field indices and the subtract/compare reference function
package comp_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;
  localparam int REF_MAX_W = 16;
  localparam int CIN_BIT = 0;
  localparam int B_LSB = 1;
  // Returns {Out, D[REF_MAX_W-1:0], AgB, AlB, AeB}; only the low w bits of D are meaningful.
  function automatic logic [REF_MAX_W+3:0] comp_ref(input logic [REF_MAX_W-1:0] a, b, input logic cin, input int w);
    logic [REF_MAX_W-1:0] mask, a_m, b_m;
    logic [REF_MAX_W:0] sum;
    mask = (REF_MAX_W'(1) << w) - REF_MAX_W'(1);
    a_m = a & mask;
    b_m = ~b & mask;
    sum = {1'b0, a_m} + {1'b0, b_m} + {{REF_MAX_W{1'b0}}, cin};
    return {|(sum >> w), sum[REF_MAX_W-1:0] & mask, a_m > (b & mask), a_m < (b & mask), a_m == (b & mask)};
  endfunction
endpackage

// File: rtl/comp_ref_model.sv
// comp_ref_model: combinational golden model of the WIDTH-bit compare/subtract unit
module comp_ref_model import comp_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] d,
  output logic             out,
  output logic             agb,
  output logic             alb,
  output logic             aeb
);
  logic [REF_MAX_W+3:0] r;
  logic unused_hi;
  assign r = comp_ref(REF_MAX_W'(a), REF_MAX_W'(b), cin, WIDTH);
  assign {agb, alb, aeb} = r[2:0];
  assign d = r[3 +: WIDTH];
  assign out = r[REF_MAX_W+3];
  assign unused_hi = ^(r[REF_MAX_W+2:3] >> WIDTH);
endmodule

// File: rtl/comp_sweep_checker.sv
// comp_sweep_checker: BIST sweeping all {A,B,Cin} into a compare/subtract unit and checking its outputs.
// Optional COMP_SWEEP_STOP_ON_ERR_EN: end the sweep at the first mismatching vector.
module comp_sweep_checker import comp_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int SETTLE = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     A_o,
  output logic [WIDTH-1:0]     B_o,
  output logic                 Cin_o,
  input  logic [WIDTH-1:0]     D_i,
  input  logic                 Out_i,
  input  logic                 AgB_i,
  input  logic                 AlB_i,
  input  logic                 AeB_i,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [2*WIDTH:0]     first_err_vec
);
  localparam int VW = 2*WIDTH+1;
  state_t state, nxt;
  logic [VW-1:0] v;
  logic [3:0] cnt;
  logic [WIDTH-1:0] m_d;
  logic m_out, m_agb, m_alb, m_aeb, mism, last, stop, launch;
  comp_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a(A_o), .b(B_o), .cin(Cin_o),
    .d(m_d), .out(m_out), .agb(m_agb), .alb(m_alb), .aeb(m_aeb)
  );
  assign A_o = v[B_LSB+WIDTH +: WIDTH];
  assign B_o = v[B_LSB +: WIDTH];
  assign Cin_o = v[CIN_BIT];
  assign mism = {D_i, Out_i, AgB_i, AlB_i, AeB_i} != {m_d, m_out, m_agb, m_alb, m_aeb};
  assign last = &v;
`ifdef COMP_SWEEP_STOP_ON_ERR_EN
  assign stop = last | mism;
`else
  assign stop = last;
`endif
  assign launch = (state == IDLE || state == DONE) && start;
  assign busy = state == WAIT || state == CHECK;
  assign done = state == DONE;
  assign pass = done && err_count == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = launch ? WAIT : state == WAIT ? (cnt == '0 ? CHECK : WAIT) : state == CHECK ? (stop ? DONE : WAIT) : state;
  // err_count never returns to zero within a sweep, so zero marks "no mismatch captured yet"
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      cnt <= '0;
      err_count <= '0;
      first_err_vec <= '0;
    end else if (launch) begin
      v <= '0;
      cnt <= 4'(SETTLE);
      err_count <= '0;
      first_err_vec <= '0;
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - 4'd1;
    end else if (state == CHECK) begin
      if (mism && err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
      if (mism && err_count == '0) first_err_vec <= v;
      if (!stop) begin
        v <= v + VW'(1);
        cnt <= 4'(SETTLE);
      end
    end
endmodule
